// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the three buses around the data-memory port arbiter:
//   cpu_*  : MEM-stage request channel (req/we/addr/wdata in, rdata/done out)
//            plus cpu_stall towards the hazard unit
//   dbg_*  : debug-port request channel (req/we/addr/wdata in, rdata/done out)
//   mem_*  : single data-memory port (en/we/addr/wdata out, rdata in)
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters and memory)
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if;
    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_stall;

    logic        dbg_req;
    logic [3:0]  dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_done;

    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single data-memory port between the CPU MEM stage and the
// debug port. Each access walks IDLE -> ISSUE -> WAIT -> RESP; the memory
// answers a fixed MEM_LATENCY cycles after the mem_en strobe. Ties are
// broken round-robin against the previous grant.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : dmem_port_arbiter_if.slave (cpu_*, dbg_*, mem_* buses)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           last_grant_q, last_grant_d;
    logic [3:0]       we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cpu_rdata_q, cpu_rdata_d;
    logic [31:0]      dbg_rdata_q, dbg_rdata_d;

    logic             mem_en_c;
    logic [3:0]       mem_we_c;
    logic             cpu_done_c;
    logic             dbg_done_c;
    logic             grant_dbg;

    // Debug wins only if it is alone, or if both ask and the CPU had the
    // previous grant.
    assign grant_dbg = bus.dbg_req & (~bus.cpu_req | (last_grant_q == OWN_CPU));

    // State register and latched request fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_DBG;
            we_q         <= 4'h0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            cnt_q        <= '0;
            cpu_rdata_q  <= 32'h0;
            dbg_rdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        mem_en_c     = 1'b0;
        mem_we_c     = 4'h0;
        cpu_done_c   = 1'b0;
        dbg_done_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    if (grant_dbg) begin
                        owner_d      = OWN_DBG;
                        last_grant_d = OWN_DBG;
                        we_d         = bus.dbg_we;
                        addr_d       = bus.dbg_addr;
                        wdata_d      = bus.dbg_wdata;
                    end else begin
                        owner_d      = OWN_CPU;
                        last_grant_d = OWN_CPU;
                        we_d         = bus.cpu_we;
                        addr_d       = bus.cpu_addr;
                        wdata_d      = bus.cpu_wdata;
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                mem_en_c = 1'b1;
                mem_we_c = we_q;
                // WAIT lasts MEM_LATENCY cycles; the last one sees cnt_q==0
                // and lines up with mem_rdata becoming valid.
                cnt_d    = CNT_W'(MEM_LATENCY - 1);
                state_d  = ST_WAIT;
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q == OWN_DBG) begin
                        dbg_rdata_d = bus.mem_rdata;
                    end else begin
                        cpu_rdata_d = bus.mem_rdata;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RESP: begin
                cpu_done_c = (owner_q == OWN_CPU);
                dbg_done_c = (owner_q == OWN_DBG);
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_done  = cpu_done_c;
    assign bus.dbg_done  = dbg_done_c;
    // Combinational so the hazard unit sees the stall in the request cycle,
    // and drops it in the completion cycle so the pipeline advances.
    assign bus.cpu_stall = bus.cpu_req & ~cpu_done_c;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter: one instance with MEM_LATENCY=2 and
// one with MEM_LATENCY=1, each backed by a small behavioural memory that
// returns read data MEM_LATENCY cycles after mem_en.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    dmem_port_arbiter_if bus0 ();
    dmem_port_arbiter_if bus1 ();

    dmem_port_arbiter #(.MEM_LATENCY(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    dmem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind dut0: two-stage read pipe, byte-enabled writes.
    logic [31:0] mem0 [0:255];
    logic [31:0] pipe0_a, pipe0_b;
    always @(posedge clk) begin
        if (bus0.mem_en) begin
            pipe0_a <= mem0[bus0.mem_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (bus0.mem_we[b]) mem0[bus0.mem_addr[9:2]][8*b +: 8] <= bus0.mem_wdata[8*b +: 8];
            end
        end else begin
            pipe0_a <= 32'h0;
        end
        pipe0_b <= pipe0_a;
    end
    assign bus0.mem_rdata = pipe0_b;

    // Memory behind dut1: single-stage read pipe, read-only here.
    logic [31:0] mem1 [0:255];
    logic [31:0] pipe1_a;
    always @(posedge clk) begin
        pipe1_a <= bus1.mem_en ? mem1[bus1.mem_addr[9:2]] : 32'h0;
    end
    assign bus1.mem_rdata = pipe1_a;

    // One line per completed transaction.
    always @(negedge clk) begin
        if (bus0.cpu_done === 1'b1) $display("txn L2 cpu done rdata=%h", bus0.cpu_rdata);
        if (bus0.dbg_done === 1'b1) $display("txn L2 dbg done rdata=%h", bus0.dbg_rdata);
        if (bus1.cpu_done === 1'b1) $display("txn L1 cpu done rdata=%h", bus1.cpu_rdata);
    end

    task automatic test_reset();
        rst = 1'b0;
        bus0.cpu_req = 1'b1;
        @(posedge clk); #1;
        vectors++; if (bus0.mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en got %b expected 0", bus0.mem_en); end
        vectors++; if (bus0.mem_we !== 4'h0) begin miscompares++; $display("FAIL rst_mem_we got %h expected 0", bus0.mem_we); end
        vectors++; if (bus0.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr got %h expected 0", bus0.mem_addr); end
        vectors++; if (bus0.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata got %h expected 0", bus0.mem_wdata); end
        vectors++; if (bus0.cpu_done !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_done got %b expected 0", bus0.cpu_done); end
        vectors++; if (bus0.dbg_done !== 1'b0) begin miscompares++; $display("FAIL rst_dbg_done got %b expected 0", bus0.dbg_done); end
        vectors++; if (bus0.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_cpu_rdata got %h expected 0", bus0.cpu_rdata); end
        vectors++; if (bus0.dbg_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_dbg_rdata got %h expected 0", bus0.dbg_rdata); end
        vectors++; if (bus0.cpu_stall !== 1'b1) begin miscompares++; $display("FAIL rst_stall_hi got %b expected 1", bus0.cpu_stall); end
        vectors++; if (bus1.mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_l1_mem_en got %b expected 0", bus1.mem_en); end
        bus0.cpu_req = 1'b0;
        #1;
        vectors++; if (bus0.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall_lo got %b expected 0", bus0.cpu_stall); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // CPU read of 0x100: strobe at t=1, done at t=4, stall t=0..3.
    task automatic test_cpu_read();
        @(posedge clk); #1;
        bus0.cpu_req = 1'b1; bus0.cpu_we = 4'h0; bus0.cpu_addr = 32'h100; bus0.cpu_wdata = 32'h0;
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            vectors++; if (bus0.mem_en !== (t == 1)) begin miscompares++; $display("FAIL rd_mem_en t=%0d got %b expected %b", t, bus0.mem_en, (t == 1)); end
            vectors++; if (bus0.cpu_done !== (t == 4)) begin miscompares++; $display("FAIL rd_cpu_done t=%0d got %b expected %b", t, bus0.cpu_done, (t == 4)); end
            vectors++; if (bus0.cpu_stall !== (t <= 3)) begin miscompares++; $display("FAIL rd_cpu_stall t=%0d got %b expected %b", t, bus0.cpu_stall, (t <= 3)); end
            if (t == 1) begin
                vectors++; if (bus0.mem_addr !== 32'h100) begin miscompares++; $display("FAIL rd_mem_addr got %h expected 00000100", bus0.mem_addr); end
                vectors++; if (bus0.mem_we !== 4'h0) begin miscompares++; $display("FAIL rd_mem_we got %h expected 0", bus0.mem_we); end
            end
            if (t >= 4) begin
                vectors++; if (bus0.cpu_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_cpu_rdata t=%0d got %h expected deadbeef", t, bus0.cpu_rdata); end
            end
            if (t == 4) bus0.cpu_req = 1'b0;
        end
    endtask

    // Tie right after reset: CPU first (done t=4), debug next (done t=9),
    // next tie back to CPU (done t=14).
    task automatic test_round_robin();
        logic exp_cpu_done;
        logic exp_dbg_done;
        rst = 1'b0;
        @(posedge clk); #1;
        bus0.cpu_req = 1'b1; bus0.cpu_we = 4'h0; bus0.cpu_addr = 32'h100;
        bus0.dbg_req = 1'b1; bus0.dbg_we = 4'h0; bus0.dbg_addr = 32'h104; bus0.dbg_wdata = 32'h0;
        rst = 1'b1;
        for (int t = 0; t <= 14; t++) begin
            @(negedge clk);
            exp_cpu_done = (t == 4) || (t == 14);
            exp_dbg_done = (t == 9);
            vectors++; if (bus0.mem_en !== ((t == 1) || (t == 6) || (t == 11))) begin miscompares++; $display("FAIL rr_mem_en t=%0d got %b", t, bus0.mem_en); end
            vectors++; if (bus0.cpu_done !== exp_cpu_done) begin miscompares++; $display("FAIL rr_cpu_done t=%0d got %b expected %b", t, bus0.cpu_done, exp_cpu_done); end
            vectors++; if (bus0.dbg_done !== exp_dbg_done) begin miscompares++; $display("FAIL rr_dbg_done t=%0d got %b expected %b", t, bus0.dbg_done, exp_dbg_done); end
            if (t == 6) begin
                vectors++; if (bus0.mem_addr !== 32'h104) begin miscompares++; $display("FAIL rr_dbg_addr got %h expected 00000104", bus0.mem_addr); end
            end
            if (t == 11) begin
                vectors++; if (bus0.mem_addr !== 32'h100) begin miscompares++; $display("FAIL rr_cpu_addr got %h expected 00000100", bus0.mem_addr); end
            end
            if (t == 9) begin
                vectors++; if (bus0.dbg_rdata !== 32'h11112222) begin miscompares++; $display("FAIL rr_dbg_rdata got %h expected 11112222", bus0.dbg_rdata); end
            end
            if (t == 11) bus0.dbg_req = 1'b0;
            if (t == 14) bus0.cpu_req = 1'b0;
        end
    endtask

    // Debug byte write 0x12345678 with we=0011 to 0x8.
    task automatic test_dbg_write();
        @(posedge clk); #1;
        bus0.dbg_req = 1'b1; bus0.dbg_we = 4'b0011; bus0.dbg_addr = 32'h8; bus0.dbg_wdata = 32'h12345678;
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            vectors++; if (bus0.mem_we !== ((t == 1) ? 4'b0011 : 4'b0000)) begin miscompares++; $display("FAIL wr_mem_we t=%0d got %b", t, bus0.mem_we); end
            vectors++; if (bus0.dbg_done !== (t == 4)) begin miscompares++; $display("FAIL wr_dbg_done t=%0d got %b expected %b", t, bus0.dbg_done, (t == 4)); end
            vectors++; if (bus0.cpu_done !== 1'b0) begin miscompares++; $display("FAIL wr_cpu_done t=%0d got %b expected 0", t, bus0.cpu_done); end
            if (t == 1) begin
                vectors++; if (bus0.mem_wdata !== 32'h12345678) begin miscompares++; $display("FAIL wr_mem_wdata got %h expected 12345678", bus0.mem_wdata); end
                vectors++; if (bus0.mem_addr !== 32'h8) begin miscompares++; $display("FAIL wr_mem_addr got %h expected 00000008", bus0.mem_addr); end
            end
            if (t == 4) bus0.dbg_req = 1'b0;
        end
        vectors++; if (mem0[2] !== 32'hAAAA5678) begin miscompares++; $display("FAIL wr_mem_word got %h expected aaaa5678", mem0[2]); end
    endtask

    // Address changed during WAIT must not reach the memory.
    task automatic test_addr_change();
        @(posedge clk); #1;
        bus0.cpu_req = 1'b1; bus0.cpu_we = 4'h0; bus0.cpu_addr = 32'h100;
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            if (t == 2) bus0.cpu_addr = 32'h200;
            if (t >= 2) begin
                vectors++; if (bus0.mem_addr !== 32'h100) begin miscompares++; $display("FAIL ac_mem_addr t=%0d got %h expected 00000100", t, bus0.mem_addr); end
            end
            vectors++; if (bus0.cpu_done !== (t == 4)) begin miscompares++; $display("FAIL ac_cpu_done t=%0d got %b expected %b", t, bus0.cpu_done, (t == 4)); end
            if (t == 4) begin
                vectors++; if (bus0.cpu_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ac_cpu_rdata got %h expected deadbeef", bus0.cpu_rdata); end
                bus0.cpu_req = 1'b0;
            end
        end
    endtask

    // Asynchronous reset in WAIT: outputs clear at once, no done, and the
    // held request is arbitrated again after release.
    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        bus0.cpu_req = 1'b1; bus0.cpu_we = 4'h0; bus0.cpu_addr = 32'h104;
        for (int t = 0; t <= 2; t++) begin
            @(negedge clk);
            vectors++; if (bus0.mem_en !== (t == 1)) begin miscompares++; $display("FAIL rw_pre_mem_en t=%0d got %b expected %b", t, bus0.mem_en, (t == 1)); end
        end
        rst = 1'b0;
        #1;
        vectors++; if (bus0.mem_en !== 1'b0) begin miscompares++; $display("FAIL rw_mem_en got %b expected 0", bus0.mem_en); end
        vectors++; if (bus0.mem_we !== 4'h0) begin miscompares++; $display("FAIL rw_mem_we got %h expected 0", bus0.mem_we); end
        vectors++; if (bus0.cpu_done !== 1'b0) begin miscompares++; $display("FAIL rw_cpu_done got %b expected 0", bus0.cpu_done); end
        vectors++; if (bus0.dbg_done !== 1'b0) begin miscompares++; $display("FAIL rw_dbg_done got %b expected 0", bus0.dbg_done); end
        vectors++; if (bus0.cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL rw_cpu_rdata got %h expected 0", bus0.cpu_rdata); end
        vectors++; if (bus0.dbg_rdata !== 32'h0) begin miscompares++; $display("FAIL rw_dbg_rdata got %h expected 0", bus0.dbg_rdata); end
        vectors++; if (bus0.cpu_stall !== 1'b1) begin miscompares++; $display("FAIL rw_cpu_stall got %b expected 1", bus0.cpu_stall); end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            vectors++; if (bus0.mem_en !== (t == 1)) begin miscompares++; $display("FAIL rw_post_mem_en t=%0d got %b expected %b", t, bus0.mem_en, (t == 1)); end
            vectors++; if (bus0.cpu_done !== (t == 4)) begin miscompares++; $display("FAIL rw_post_done t=%0d got %b expected %b", t, bus0.cpu_done, (t == 4)); end
            if (t == 4) begin
                vectors++; if (bus0.cpu_rdata !== 32'h11112222) begin miscompares++; $display("FAIL rw_post_rdata got %h expected 11112222", bus0.cpu_rdata); end
                bus0.cpu_req = 1'b0;
            end
        end
    endtask

    // MEM_LATENCY=1 with a held request: strobe at 1,5,9 and done at 3,7,11.
    task automatic test_latency_one();
        @(posedge clk); #1;
        bus1.cpu_req = 1'b1; bus1.cpu_we = 4'h0; bus1.cpu_addr = 32'h100;
        for (int t = 0; t <= 11; t++) begin
            @(negedge clk);
            vectors++; if (bus1.mem_en !== ((t % 4) == 1)) begin miscompares++; $display("FAIL l1_mem_en t=%0d got %b expected %b", t, bus1.mem_en, ((t % 4) == 1)); end
            vectors++; if (bus1.cpu_done !== ((t % 4) == 3)) begin miscompares++; $display("FAIL l1_cpu_done t=%0d got %b expected %b", t, bus1.cpu_done, ((t % 4) == 3)); end
            vectors++; if (bus1.cpu_stall !== ((t % 4) != 3)) begin miscompares++; $display("FAIL l1_cpu_stall t=%0d got %b expected %b", t, bus1.cpu_stall, ((t % 4) != 3)); end
            if ((t % 4) == 3) begin
                vectors++; if (bus1.cpu_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL l1_cpu_rdata t=%0d got %h expected cafef00d", t, bus1.cpu_rdata); end
            end
            if (t == 11) bus1.cpu_req = 1'b0;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        mem0[8'h40] = 32'hDEADBEEF;
        mem0[8'h41] = 32'h11112222;
        mem0[8'h80] = 32'h0BADF00D;
        mem0[8'h02] = 32'hAAAAAAAA;
        mem1[8'h40] = 32'hCAFEF00D;

        rst = 1'b0;
        bus0.cpu_req = 1'b0; bus0.cpu_we = 4'h0; bus0.cpu_addr = 32'h0; bus0.cpu_wdata = 32'h0;
        bus0.dbg_req = 1'b0; bus0.dbg_we = 4'h0; bus0.dbg_addr = 32'h0; bus0.dbg_wdata = 32'h0;
        bus1.cpu_req = 1'b0; bus1.cpu_we = 4'h0; bus1.cpu_addr = 32'h0; bus1.cpu_wdata = 32'h0;
        bus1.dbg_req = 1'b0; bus1.dbg_we = 4'h0; bus1.dbg_addr = 32'h0; bus1.dbg_wdata = 32'h0;

        test_reset();
        test_cpu_read();
        test_round_robin();
        test_dbg_write();
        test_addr_change();
        test_reset_mid_wait();
        test_latency_one();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
